// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // Bit-counter width able to hold 0..width.
    function automatic int unsigned sub_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sub_bit_step.sv
// One-bit subtract step: two half-subtractor cells and an OR on the borrows.
module sub_bit_step (
    input  logic a_i,
    input  logic b_i,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    logic d1;
    logic b1;
    logic b2;

    assign d1     = a_i ^ b_i;
    assign b1     = ~a_i & b_i;
    assign d      = d1 ^ br_in;
    assign b2     = ~d1 & br_in;
    assign br_out = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: sequences one sub_bit_step over WIDTH bits, LSB first,
// between a valid/ready operand handshake and a valid/ready result handshake.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dif,
    output logic             bor,
    output logic             busy
);

    localparam int unsigned      CNT_W    = sub_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] dif_q, dif_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bor_q, bor_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             step_d;
    logic             step_br;
    logic [WIDTH-1:0] res_shift;

    sub_bit_step u_step (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .br_in  (br_q),
        .d      (step_d),
        .br_out (step_br)
    );

    // New difference bit enters at the MSB so the LSB-first stream lands in place.
    assign res_shift = (res_q >> 1) | (WIDTH'(step_d) << (WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        dif_d       = dif_q;
        cnt_d       = cnt_q;
        br_d        = br_q;
        bor_d       = bor_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    res_d      = '0;
                    br_d       = 1'b0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = step_br;
                res_d = res_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    dif_d       = res_shift;
                    bor_d       = step_br;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // A simultaneous in_valid is left for the following IDLE cycle.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            dif_q       <= '0;
            cnt_q       <= '0;
            br_q        <= 1'b0;
            bor_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            dif_q       <= dif_d;
            cnt_q       <= cnt_d;
            br_q        <= br_d;
            bor_q       <= bor_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dif       = dif_q;
    assign bor       = bor_q;
    assign busy      = busy_q;

endmodule
